lcd_write_sequencer: RTL and testbench

Sequencer and scheduler for the HD44780-class character LCD on the Nios II custom-instruction bus. After reset it waits out LCD power-up and plays a fixed four-command init ROM. It then drains a FIFO of CPU-queued {rs, byte} writes, generating every enable pulse and busy wait itself, so software issues single-cycle custom instructions instead of blocking per byte.

---
 rtl/lcd_write_sequencer_if.sv | 28 ++
 rtl/lcd_write_sequencer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_lcd_write_sequencer.sv | 592 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_write_sequencer_if.sv
// ---------------------------------------------------------------------------
// lcd_write_sequencer_if
// Nios II custom-instruction host bus for the LCD write sequencer.
//   clk_en : custom-instruction clock enable (master -> slave)
//   start  : instruction strobe, honoured only with clk_en=1
//   dataA  : [1:0] opcode, [2] rs for PUSH
//   dataB  : [7:0] byte for PUSH
//   done   : one-cycle completion pulse (slave -> master)
//   result : instruction return value, held until the next instruction
// ---------------------------------------------------------------------------
interface lcd_write_sequencer_if;
    logic        clk_en;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        done;
    logic [31:0] result;

    modport master (
        output clk_en, start, dataA, dataB,
        input  done, result
    );

    modport slave (
        input  clk_en, start, dataA, dataB,
        output done, result
    );
endinterface

// File: rtl/lcd_write_sequencer.sv
// ---------------------------------------------------------------------------
// lcd_write_sequencer
// Drives an HD44780-class character LCD. After reset it waits out LCD
// power-up, plays a four-command init ROM, then drains a FIFO of
// CPU-queued {rs, byte} writes, generating every enable pulse and busy wait.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   host      slave modport of lcd_write_sequencer_if (custom-instruction bus)
//   lcd_rs    out  LCD register select
//   lcd_rw    out  LCD read/write, tied 0 (write only)
//   lcd_en    out  LCD enable strobe
//   lcd_data  out  LCD data bus
//   init_done out  init ROM finished; FIFO is being serviced
// ---------------------------------------------------------------------------
module lcd_write_sequencer #(
    parameter int PULSE_CYC      = 50,
    parameter int WAIT_CYC       = 2500,
    parameter int CLEAR_WAIT_CYC = 100000,
    parameter int POWERUP_CYC    = 2000000,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    lcd_write_sequencer_if.slave        host,
    output logic                        lcd_rs,
    output logic                        lcd_rw,
    output logic                        lcd_en,
    output logic [7:0]                  lcd_data,
    output logic                        init_done
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [31:0] PWR_LAST   = 32'(POWERUP_CYC - 1);
    localparam logic [31:0] PULSE_LAST = 32'(PULSE_CYC - 1);
    localparam logic [31:0] WAIT_LAST  = 32'(WAIT_CYC - 1);
    localparam logic [31:0] CLEAR_LAST = 32'(CLEAR_WAIT_CYC - 1);
    localparam logic [AW:0] CNT_FULL   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);

    typedef enum logic [2:0] {
        S_POWERUP,
        S_LOAD,
        S_SETUP,
        S_PULSE,
        S_WAIT,
        S_IDLE
    } state_t;

    // Init ROM: function set 8-bit/2-line, display on, entry mode, clear.
    function automatic logic [7:0] rom_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    rom_byte = 8'h38;
            2'd1:    rom_byte = 8'h0C;
            2'd2:    rom_byte = 8'h06;
            default: rom_byte = 8'h01;
        endcase
    endfunction

    // Engine state
    state_t        r_state, w_state_nxt;
    logic [31:0]   r_cnt, w_cnt_nxt;
    logic [2:0]    r_rom_idx;
    logic          r_init_done;
    logic          r_rs;
    logic [7:0]    r_data;

    // Write queue
    logic [8:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    // Host return registers
    logic          r_done;
    logic [31:0]   r_result;

    // Host decode
    logic          w_cmd;
    logic [1:0]    w_op;
    logic          w_full;
    logic          w_push;
    logic          w_reinit;
    logic          w_fifo_empty;
    logic          w_src_fifo;
    logic          w_pop;
    logic          w_rom_load;
    logic          w_busy;
    logic [31:0]   w_wait_last;
    logic          w_unused;

    assign w_cmd        = host.start & host.clk_en;
    assign w_op         = host.dataA[1:0];
    assign w_full       = (r_count == CNT_FULL);
    // Fullness is judged before any same-cycle pop, so a full queue rejects.
    assign w_push       = w_cmd && (w_op == 2'b00) && !w_full;
    assign w_reinit     = w_cmd && (w_op == 2'b10);
    assign w_fifo_empty = (r_count == '0);

    // Once all four ROM entries have been played, the LOAD that follows
    // switches over to the FIFO and raises init_done in the same cycle.
    assign w_src_fifo   = r_init_done || (r_rom_idx == 3'd4);
    assign w_pop        = (r_state == S_LOAD) && w_src_fifo && !w_fifo_empty;
    assign w_rom_load   = (r_state == S_LOAD) && !w_src_fifo;
    assign w_busy       = (r_state != S_IDLE);

    // Clear and return-home need the long busy wait.
    assign w_wait_last  = (!r_rs && (r_data == 8'h01 || r_data == 8'h02))
                          ? CLEAR_LAST : WAIT_LAST;

    assign w_unused     = &{1'b0, host.dataA[31:3], host.dataB[31:8]};

    // -----------------------------------------------------------------------
    // Engine FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_POWERUP;
            r_cnt       <= '0;
            r_rom_idx   <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_rom_load)
                r_rom_idx <= r_rom_idx + 3'd1;
            if ((r_state == S_LOAD) && w_src_fifo)
                r_init_done <= 1'b1;
            // REINIT overrides: the running pulse/wait finishes on its own,
            // and the next LOAD restarts the ROM at entry 0.
            if (w_reinit) begin
                r_rom_idx   <= '0;
                r_init_done <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Engine FSM: next state and phase counter
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_POWERUP: begin
                if (r_cnt == PWR_LAST) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            S_LOAD: begin
                w_cnt_nxt = '0;
                if (w_pop || w_rom_load)
                    w_state_nxt = S_SETUP;
                else
                    w_state_nxt = S_IDLE;
            end
            S_SETUP: begin
                w_state_nxt = S_PULSE;
                w_cnt_nxt   = '0;
            end
            S_PULSE: begin
                if (r_cnt == PULSE_LAST) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            S_WAIT: begin
                if (r_cnt == w_wait_last) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            S_IDLE: begin
                // An uninitialised display (after REINIT) also needs service.
                if (!w_fifo_empty || !r_init_done)
                    w_state_nxt = S_LOAD;
            end
            default: begin
                w_state_nxt = S_POWERUP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Transfer latch: rs/data held from SETUP through the end of WAIT
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rs   <= 1'b0;
            r_data <= 8'h00;
        end else if (w_rom_load) begin
            r_rs   <= 1'b0;
            r_data <= rom_byte(r_rom_idx[1:0]);
        end else if (w_pop) begin
            r_rs   <= r_mem[r_rd_ptr][8];
            r_data <= r_mem[r_rd_ptr][7:0];
        end
    end

    // -----------------------------------------------------------------------
    // Write queue
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {host.dataA[2], host.dataB[7:0]};
    end

    always_ff @(posedge clk) begin
        if (reset || w_reinit) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Host return path: done one cycle after start, result held until next
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= w_cmd;
            if (w_cmd) begin
                case (w_op)
                    2'b00:   r_result <= {31'b0, w_full};
                    // Occupancy is the pre-pop value of this cycle.
                    2'b01:   r_result <= {22'b0, w_busy, r_init_done, 3'b0, 5'(r_count)};
                    default: r_result <= '0;
                endcase
            end
        end
    end

    assign host.done   = r_done;
    assign host.result = r_result;

    assign lcd_en    = (r_state == S_PULSE);
    assign lcd_rw    = 1'b0;
    assign lcd_rs    = r_rs;
    assign lcd_data  = r_data;
    assign init_done = r_init_done;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lcd_write_sequencer
// Self-checking bench for lcd_write_sequencer with small timing parameters.
// A negedge monitor records every enable pulse (rs, data, pulse length,
// low gap before it) and flags rs/data changes inside a pulse or its wait.
// Scenario tasks compare the recorded transfers against expectations built
// from the LCD protocol rules.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_write_sequencer;

    localparam int PULSE = 2;
    localparam int WAITC = 4;
    localparam int CLRW  = 8;
    localparam int PWR   = 10;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lcd_rs, lcd_rw, lcd_en, init_done;
    logic [7:0] lcd_data;

    lcd_write_sequencer_if hif();

    lcd_write_sequencer #(
        .PULSE_CYC(PULSE), .WAIT_CYC(WAITC), .CLEAR_WAIT_CYC(CLRW),
        .POWERUP_CYC(PWR), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .host(hif),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_data(lcd_data), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         plen;
        int         gap;
        int         fall_cyc;
    } xfer_t;

    xfer_t obs_q[$];
    int    obs_rd = 0;

    function automatic int exp_wait(input logic rs, input logic [7:0] d);
        if (!rs && (d == 8'h01 || d == 8'h02)) return CLRW;
        return WAITC;
    endfunction

    // Monitor
    int    cyc = 0;
    int    stab_err = 0;
    int    init_rise_cyc = -1;
    logic  m_prev_en = 1'b0;
    logic  m_prev_init = 1'b0;
    xfer_t m_cur;
    int    m_low = 0;
    int    m_hold = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            m_prev_en   = 1'b0;
            m_prev_init = 1'b0;
            m_low       = 0;
            m_hold      = 0;
        end else begin
            if (init_done && !m_prev_init) init_rise_cyc = cyc;
            m_prev_init = init_done;
            if (lcd_en) begin
                if (!m_prev_en) begin
                    m_cur.rs   = lcd_rs;
                    m_cur.data = lcd_data;
                    m_cur.plen = 1;
                    m_cur.gap  = m_low;
                end else begin
                    m_cur.plen = m_cur.plen + 1;
                    if (lcd_rs !== m_cur.rs || lcd_data !== m_cur.data) stab_err = stab_err + 1;
                end
                m_low = 0;
            end else begin
                if (m_prev_en) begin
                    m_cur.fall_cyc = cyc;
                    obs_q.push_back(m_cur);
                    m_hold = exp_wait(m_cur.rs, m_cur.data);
                end
                if (m_hold > 0) begin
                    if (lcd_rs !== m_cur.rs || lcd_data !== m_cur.data) stab_err = stab_err + 1;
                    m_hold = m_hold - 1;
                end
                m_low = m_low + 1;
            end
            m_prev_en = lcd_en;
        end
    end

    // Bus/wait helpers (no comparisons inside)
    task automatic drive(input logic [1:0] op, input logic rs, input logic [7:0] b);
        hif.clk_en = 1'b1;
        hif.start  = 1'b1;
        hif.dataA  = {29'b0, rs, op};
        hif.dataB  = {24'b0, b};
    endtask

    task automatic bus_idle();
        hif.start = 1'b0;
        hif.dataA = '0;
        hif.dataB = '0;
    endtask

    task automatic host_op(input logic [1:0] op, input logic rs, input logic [7:0] b,
                           output logic d, output logic [31:0] r);
        @(negedge clk);
        drive(op, rs, b);
        @(negedge clk);
        d = hif.done;
        r = hif.result;
        bus_idle();
    endtask

    task automatic wait_obs(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (obs_q.size() >= obs_rd + n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_en(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (lcd_en === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        idle_cycles(3);
        n_checks++;
        if (hif.done !== 1'b0 || hif.result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_host: done=%b result=%h, required done=0 result=0", hif.done, hif.result);
        end
        n_checks++;
        if ({lcd_en, lcd_rs, lcd_rw, lcd_data} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_lcd: en=%b rs=%b rw=%b data=%h, required all 0", lcd_en, lcd_rs, lcd_rw, lcd_data);
        end
        n_checks++;
        if (init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init_done: got %b, required 0", init_done);
        end
    endtask

    // Called at a negedge right after reset is released (or REINIT-free boot).
    task automatic test_init();
        logic [7:0] rom_exp [4];
        int         en_hi;
        int         last_fall;
        bit         ok;
        xfer_t      x;
        rom_exp = '{8'h38, 8'h0C, 8'h06, 8'h01};
        en_hi = 0;
        for (int i = 0; i < PWR; i++) begin
            @(negedge clk);
            if (lcd_en !== 1'b0 || lcd_rw !== 1'b0) en_hi++;
        end
        n_checks++;
        if (en_hi != 0) begin
            n_fail++;
            $display("FAIL powerup_quiet: en high in %0d cycles, required 0", en_hi);
        end
        wait_obs(4, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL init_timeout: got %0d transfers, required 4", obs_q.size() - obs_rd);
            return;
        end
        last_fall = 0;
        for (int i = 0; i < 4; i++) begin
            x = obs_q[obs_rd];
            obs_rd++;
            n_checks++;
            if (x.rs !== 1'b0 || x.data !== rom_exp[i] || x.plen != PULSE) begin
                n_fail++;
                $display("FAIL init_cmd%0d: rs=%b data=%h plen=%0d, required rs=0 data=%h plen=%0d",
                         i, x.rs, x.data, x.plen, rom_exp[i], PULSE);
            end
            if (i > 0) begin
                n_checks++;
                if (x.gap != WAITC + 2) begin
                    n_fail++;
                    $display("FAIL init_gap%0d: got %0d, required %0d", i, x.gap, WAITC + 2);
                end
            end
            last_fall = x.fall_cyc;
        end
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (init_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        n_checks++;
        if (!ok || init_rise_cyc - last_fall != CLRW + 1) begin
            n_fail++;
            $display("FAIL init_done_timing: rise %0d cycles after last fall, required %0d",
                     init_rise_cyc - last_fall, CLRW + 1);
        end
    endtask

    task automatic test_single_push();
        logic        d;
        logic [31:0] r;
        bit          ok;
        xfer_t       x;
        host_op(2'b00, 1'b1, 8'h41, d, r);
        n_checks++;
        if (d !== 1'b1 || r !== 32'h0) begin
            n_fail++;
            $display("FAIL push_ack: done=%b result=%h, required done=1 result=0", d, r);
        end
        @(negedge clk);
        n_checks++;
        if (hif.done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: done=%b two cycles after start, required 0", hif.done);
        end
        wait_obs(1, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL push_timeout: no transfer, required 1");
            return;
        end
        x = obs_q[obs_rd];
        obs_rd++;
        n_checks++;
        if (x.rs !== 1'b1 || x.data !== 8'h41 || x.plen != PULSE) begin
            n_fail++;
            $display("FAIL push_xfer: rs=%b data=%h plen=%0d, required rs=1 data=41 plen=%0d",
                     x.rs, x.data, x.plen, PULSE);
        end
        idle_cycles(12);
    endtask

    task automatic test_back_to_back();
        logic        d;
        logic [31:0] r;
        logic        gd [5];
        logic [31:0] gr [5];
        bit          ok, ok2;
        xfer_t       x;
        logic [7:0]  exp_b;
        host_op(2'b00, 1'b0, 8'h01, d, r);
        wait_en(1'b1, ok);
        wait_en(1'b0, ok2);
        n_checks++;
        if (!ok || !ok2) begin
            n_fail++;
            $display("FAIL b2b_sync: en rise=%0b fall=%0b, required both", ok, ok2);
            return;
        end
        // Now in the first cycle of the long clear wait: five pushes in a row.
        for (int i = 0; i < 5; i++) begin
            drive(2'b00, 1'b1, 8'h50 + 8'(i));
            @(negedge clk);
            gd[i] = hif.done;
            gr[i] = hif.result;
        end
        bus_idle();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (gd[i] !== 1'b1 || gr[i] !== ((i >= DEPTH) ? 32'h1 : 32'h0)) begin
                n_fail++;
                $display("FAIL b2b_result%0d: done=%b result=%h, required done=1 result=%0d",
                         i, gd[i], gr[i], (i >= DEPTH) ? 1 : 0);
            end
        end
        wait_obs(5, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d transfers, required 5", obs_q.size() - obs_rd);
            return;
        end
        for (int i = 0; i < 5; i++) begin
            x = obs_q[obs_rd];
            obs_rd++;
            exp_b = (i == 0) ? 8'h01 : 8'h50 + 8'(i - 1);
            n_checks++;
            if (x.rs !== (i != 0) || x.data !== exp_b || x.plen != PULSE) begin
                n_fail++;
                $display("FAIL b2b_xfer%0d: rs=%b data=%h plen=%0d, required rs=%0d data=%h plen=%0d",
                         i, x.rs, x.data, x.plen, (i != 0), exp_b, PULSE);
            end
            if (i > 0) begin
                n_checks++;
                if (x.gap != ((i == 1) ? CLRW : WAITC) + 2) begin
                    n_fail++;
                    $display("FAIL b2b_gap%0d: got %0d, required %0d", i, x.gap, ((i == 1) ? CLRW : WAITC) + 2);
                end
            end
        end
        idle_cycles(30);
        n_checks++;
        if (obs_q.size() != obs_rd) begin
            n_fail++;
            $display("FAIL b2b_dropped: %0d extra transfers, required 0", obs_q.size() - obs_rd);
        end
    endtask

    task automatic test_status();
        logic        d;
        logic [31:0] r;
        logic [7:0]  b [3];
        bit          ok, ok2;
        xfer_t       x;
        host_op(2'b00, 1'b0, 8'h02, d, r);
        wait_en(1'b1, ok);
        wait_en(1'b0, ok2);
        n_checks++;
        if (!ok || !ok2) begin
            n_fail++;
            $display("FAIL status_sync: en rise=%0b fall=%0b, required both", ok, ok2);
            return;
        end
        for (int i = 0; i < 3; i++) begin
            b[i] = 8'($urandom);
            drive(2'b00, 1'b1, b[i]);
            @(negedge clk);
        end
        drive(2'b01, 1'b0, 8'h00);
        @(negedge clk);
        d = hif.done;
        r = hif.result;
        bus_idle();
        n_checks++;
        if (d !== 1'b1 || r !== {22'b0, 1'b1, 1'b1, 3'b0, 5'd3}) begin
            n_fail++;
            $display("FAIL status_busy: done=%b result=%h, required done=1 result=%h",
                     d, r, {22'b0, 1'b1, 1'b1, 3'b0, 5'd3});
        end
        wait_obs(4, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL status_timeout: got %0d transfers, required 4", obs_q.size() - obs_rd);
            return;
        end
        obs_rd++;
        for (int i = 0; i < 3; i++) begin
            x = obs_q[obs_rd];
            obs_rd++;
            n_checks++;
            if (x.rs !== 1'b1 || x.data !== b[i]) begin
                n_fail++;
                $display("FAIL status_xfer%0d: rs=%b data=%h, required rs=1 data=%h", i, x.rs, x.data, b[i]);
            end
        end
        idle_cycles(15);
        // clk_en low: the strobe must be ignored entirely.
        hif.clk_en = 1'b0;
        hif.start  = 1'b1;
        hif.dataA  = 32'h4;
        hif.dataB  = 32'hAA;
        @(negedge clk);
        n_checks++;
        if (hif.done !== 1'b0) begin
            n_fail++;
            $display("FAIL clk_en_gate: done=%b, required 0", hif.done);
        end
        bus_idle();
        host_op(2'b01, 1'b0, 8'h00, d, r);
        n_checks++;
        if (d !== 1'b1 || r !== {22'b0, 1'b0, 1'b1, 3'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL status_idle: done=%b result=%h, required done=1 result=%h",
                     d, r, {22'b0, 1'b0, 1'b1, 3'b0, 5'd0});
        end
        host_op(2'b11, 1'b0, 8'h00, d, r);
        n_checks++;
        if (d !== 1'b1 || r !== 32'h0) begin
            n_fail++;
            $display("FAIL noop: done=%b result=%h, required done=1 result=0", d, r);
        end
        idle_cycles(10);
        n_checks++;
        if (obs_q.size() != obs_rd) begin
            n_fail++;
            $display("FAIL clk_en_push: %0d transfers appeared, required 0", obs_q.size() - obs_rd);
        end
    endtask

    task automatic test_reinit();
        logic        d;
        logic [31:0] r;
        bit          ok;
        xfer_t       x;
        logic [7:0]  rom_exp [4];
        rom_exp = '{8'h38, 8'h0C, 8'h06, 8'h01};
        @(negedge clk);
        drive(2'b00, 1'b0, 8'h01);
        @(negedge clk);
        drive(2'b00, 1'b1, 8'hB1);
        @(negedge clk);
        drive(2'b00, 1'b1, 8'hB2);
        @(negedge clk);
        bus_idle();
        wait_en(1'b1, ok);
        drive(2'b10, 1'b0, 8'h00);
        @(negedge clk);
        d = hif.done;
        r = hif.result;
        bus_idle();
        n_checks++;
        if (d !== 1'b1 || r !== 32'h0 || lcd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL reinit_ack: done=%b result=%h en=%b, required done=1 result=0 en=1", d, r, lcd_en);
        end
        n_checks++;
        if (init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reinit_init_done: got %b, required 0", init_done);
        end
        wait_obs(5, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reinit_timeout: got %0d transfers, required 5", obs_q.size() - obs_rd);
            return;
        end
        x = obs_q[obs_rd];
        obs_rd++;
        n_checks++;
        if (x.data !== 8'h01 || x.plen != PULSE) begin
            n_fail++;
            $display("FAIL reinit_pulse: data=%h plen=%0d, required data=01 plen=%0d", x.data, x.plen, PULSE);
        end
        for (int i = 0; i < 4; i++) begin
            x = obs_q[obs_rd];
            obs_rd++;
            n_checks++;
            if (x.rs !== 1'b0 || x.data !== rom_exp[i]) begin
                n_fail++;
                $display("FAIL reinit_rom%0d: rs=%b data=%h, required rs=0 data=%h", i, x.rs, x.data, rom_exp[i]);
            end
            if (i == 0) begin
                n_checks++;
                if (x.gap != CLRW + 2) begin
                    n_fail++;
                    $display("FAIL reinit_gap: got %0d, required %0d", x.gap, CLRW + 2);
                end
            end
        end
        idle_cycles(15);
        n_checks++;
        if (init_done !== 1'b1 || obs_q.size() != obs_rd) begin
            n_fail++;
            $display("FAIL reinit_end: init_done=%b extra=%0d, required init_done=1 extra=0",
                     init_done, obs_q.size() - obs_rd);
        end
    endtask

    task automatic test_reset_pulse();
        logic        d;
        logic [31:0] r;
        bit          ok;
        host_op(2'b00, 1'b1, 8'h7E, d, r);
        wait_en(1'b1, ok);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (!ok || lcd_en !== 1'b0 || hif.done !== 1'b0 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulse: en=%b done=%b init_done=%b, required 0 0 0", lcd_en, hif.done, init_done);
        end
        idle_cycles(2);
        n_checks++;
        if (obs_q.size() != obs_rd) begin
            n_fail++;
            $display("FAIL reset_truncated: %0d transfers recorded, required 0", obs_q.size() - obs_rd);
        end
        reset = 1'b0;
        test_init();
    endtask

    task automatic test_random();
        logic        d;
        logic [31:0] r;
        bit          ok;
        xfer_t       x;
        logic        e_rs [3];
        logic [7:0]  e_d  [3];
        int          k;
        for (int it = 0; it < 6; it++) begin
            idle_cycles(15);
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++) begin
                e_rs[j] = 1'($urandom);
                e_d[j]  = 8'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    e_rs[j] = 1'b0;
                    e_d[j]  = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
                end
            end
            @(negedge clk);
            for (int j = 0; j < k; j++) begin
                drive(2'b00, e_rs[j], e_d[j]);
                @(negedge clk);
                n_checks++;
                if (hif.done !== 1'b1 || hif.result !== 32'h0) begin
                    n_fail++;
                    $display("FAIL rnd_ack%0d_%0d: done=%b result=%h, required done=1 result=0",
                             it, j, hif.done, hif.result);
                end
            end
            bus_idle();
            wait_obs(k, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rnd_timeout%0d: got %0d transfers, required %0d", it, obs_q.size() - obs_rd, k);
                return;
            end
            for (int j = 0; j < k; j++) begin
                x = obs_q[obs_rd];
                obs_rd++;
                n_checks++;
                if (x.rs !== e_rs[j] || x.data !== e_d[j] || x.plen != PULSE ||
                    (j > 0 && x.gap != exp_wait(e_rs[j-1], e_d[j-1]) + 2)) begin
                    n_fail++;
                    $display("FAIL rnd_xfer%0d_%0d: rs=%b data=%h plen=%0d gap=%0d, required rs=%b data=%h plen=%0d gap=%0d",
                             it, j, x.rs, x.data, x.plen, x.gap, e_rs[j], e_d[j], PULSE,
                             (j > 0) ? exp_wait(e_rs[j-1], e_d[j-1]) + 2 : x.gap);
                end
            end
        end
        idle_cycles(15);
    endtask

    initial begin
        hif.clk_en = 1'b0;
        hif.start  = 1'b0;
        hif.dataA  = '0;
        hif.dataB  = '0;
        test_reset();
        reset = 1'b0;
        test_init();
        test_single_push();
        test_back_to_back();
        test_status();
        test_reinit();
        test_random();
        test_reset_pulse();
        n_checks++;
        if (stab_err != 0) begin
            n_fail++;
            $display("FAIL rs_data_stability: %0d changes during pulse/wait, required 0", stab_err);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
